gated_sr_monitor: RTL

Synchronous self-checking monitor for a gated SR latch. It samples the latch's drive inputs (s, r, en) and its outputs (q, q_bar) every clock and runs a reference model of the latch. It flags forbidden drive, output mismatch and non-complementary outputs, and queues each error as a report on a valid/ready port. It sits on the observing side of the latch and is the hardware counterpart to the stimulus that drives the latch.

---
 rtl/gated_sr_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gated_sr_monitor.sv
// Observing-side monitor for a gated SR latch: reference model, settle-gated output checks, error reports.
// Define SRMON_SYNC_EN to pass s/r/en/q/q_bar through 2-flop synchronizers (adds 2 cycles of latency).
module gated_sr_monitor #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             en,
  input  logic             q,
  input  logic             q_bar,
  output logic [1:0]       state,
  output logic             rpt_valid,
  output logic [1:0]       rpt_code,
  input  logic             rpt_ready,
  output logic             rpt_ovf,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] forbid_cnt
);

  typedef enum logic [1:0] {
    ST_UNK    = 2'd0,
    ST_ZERO   = 2'd1,
    ST_ONE    = 2'd2,
    ST_FORBID = 2'd3
  } state_t;

  localparam logic [1:0] CODE_MISMATCH  = 2'd1;
  localparam logic [1:0] CODE_NOT_COMPL = 2'd2;
  localparam logic [1:0] CODE_FORBID    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic w_s, w_r, w_en, w_q, w_qBar;

`ifdef SRMON_SYNC_EN
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
    end else begin
      r_sync1 <= {s, r, en, q, q_bar};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_s, w_r, w_en, w_q, w_qBar} = r_sync2;
`else
  assign {w_s, w_r, w_en, w_q, w_qBar} = {s, r, en, q, q_bar};
`endif

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_settleCnt;
  logic       w_checkEn;
  logic       w_detValid;
  logic [1:0] w_detCode;
  logic       r_detValid;
  logic [1:0] r_detCode;
  logic       r_rptValid;
  logic [1:0] r_rptCode;
  logic       r_rptOvf;
  logic [CNT_W-1:0] r_errCnt;
  logic [CNT_W-1:0] r_forbidCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_UNK;
      r_settleCnt <= 4'd0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_settleCnt <= 4'(SETTLE);
      end else if (r_settleCnt != 4'd0) begin
        r_settleCnt <= r_settleCnt - 4'd1;
      end
    end
  end

  // Leaving FORBID is a race: only a decisive en=1, s!=r drive lands in a known state.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_FORBID) begin
      if (w_en && w_s && !w_r) begin
        w_nextState = ST_ONE;
      end else if (w_en && !w_s && w_r) begin
        w_nextState = ST_ZERO;
      end else if (w_en && w_s && w_r) begin
        w_nextState = ST_FORBID;
      end else begin
        w_nextState = ST_UNK;
      end
    end else if (w_en) begin
      case ({w_s, w_r})
        2'b10:   w_nextState = ST_ONE;
        2'b01:   w_nextState = ST_ZERO;
        2'b11:   w_nextState = ST_FORBID;
        default: w_nextState = r_state;
      endcase
    end
  end

  always_comb begin
    w_checkEn  = (r_settleCnt == 4'd0) && ((r_state == ST_ZERO) || (r_state == ST_ONE));
    w_detValid = 1'b0;
    w_detCode  = 2'd0;
    if ((w_nextState == ST_FORBID) && (r_state != ST_FORBID)) begin
      w_detValid = 1'b1;
      w_detCode  = CODE_FORBID;
    end else if (w_checkEn && (w_qBar == w_q)) begin
      w_detValid = 1'b1;
      w_detCode  = CODE_NOT_COMPL;
    end else if (w_checkEn && (w_q != (r_state == ST_ONE))) begin
      w_detValid = 1'b1;
      w_detCode  = CODE_MISMATCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_detValid <= 1'b0;
      r_detCode  <= 2'd0;
    end else begin
      r_detValid <= w_detValid;
      r_detCode  <= w_detCode;
    end
  end

  // An accept in the same cycle frees the slot, so a new error loads back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptValid <= 1'b0;
      r_rptCode  <= 2'd0;
      r_rptOvf   <= 1'b0;
    end else if (r_detValid) begin
      if (!r_rptValid || rpt_ready) begin
        r_rptValid <= 1'b1;
        r_rptCode  <= r_detCode;
      end else begin
        r_rptOvf <= 1'b1;
      end
    end else if (r_rptValid && rpt_ready) begin
      r_rptValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCnt    <= '0;
      r_forbidCnt <= '0;
    end else if (r_detValid) begin
      if (r_errCnt != CNT_MAX) begin
        r_errCnt <= r_errCnt + CNT_ONE;
      end
      if ((r_detCode == CODE_FORBID) && (r_forbidCnt != CNT_MAX)) begin
        r_forbidCnt <= r_forbidCnt + CNT_ONE;
      end
    end
  end

  assign state      = r_state;
  assign rpt_valid  = r_rptValid;
  assign rpt_code   = r_rptCode;
  assign rpt_ovf    = r_rptOvf;
  assign err_cnt    = r_errCnt;
  assign forbid_cnt = r_forbidCnt;

endmodule
